// File: rtl/snn_input_mem_if.sv
// snn_input_mem_if -- handshake bundle for the SNN input storage/packetiser.
//
// Channels:
//   filt_wr_*  : filter weight writes into the block (valid/ready, addr, data)
//   ifm_wr_*   : ifmap spike-bit writes into the block (valid/ready, addr, data)
//   filt_pkt_* : filter packets out of the block (valid/ready, data)
//   ifm_pkt_*  : ifmap row packets out of the block (valid/ready, data)
//
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable and does not drop valid until the beat transfers.
//
// slave  = the snn_input_mem side, master = the producer/consumer side.
interface snn_input_mem_if #(
  parameter int WIDTH_PKT = 32,
  parameter int WIDTH_FW  = 7
);
  logic                 filt_wr_valid;
  logic                 filt_wr_ready;
  logic [4:0]           filt_wr_addr;
  logic [WIDTH_FW-1:0]  filt_wr_data;

  logic                 ifm_wr_valid;
  logic                 ifm_wr_ready;
  logic [9:0]           ifm_wr_addr;
  logic                 ifm_wr_data;

  logic                 filt_pkt_valid;
  logic                 filt_pkt_ready;
  logic [WIDTH_PKT-1:0] filt_pkt_data;

  logic                 ifm_pkt_valid;
  logic                 ifm_pkt_ready;
  logic [WIDTH_PKT-1:0] ifm_pkt_data;

  modport slave (
    input  filt_wr_valid, filt_wr_addr, filt_wr_data,
    output filt_wr_ready,
    input  ifm_wr_valid, ifm_wr_addr, ifm_wr_data,
    output ifm_wr_ready,
    output filt_pkt_valid, filt_pkt_data,
    input  filt_pkt_ready,
    output ifm_pkt_valid, ifm_pkt_data,
    input  ifm_pkt_ready
  );

  modport master (
    output filt_wr_valid, filt_wr_addr, filt_wr_data,
    input  filt_wr_ready,
    output ifm_wr_valid, ifm_wr_addr, ifm_wr_data,
    input  ifm_wr_ready,
    input  filt_pkt_valid, filt_pkt_data,
    output filt_pkt_ready,
    input  ifm_pkt_valid, ifm_pkt_data,
    output ifm_pkt_ready
  );
endinterface

// File: rtl/snn_input_mem.sv
// snn_input_mem -- input-side storage and packetiser for the SNN conv mesh.
//
// Loads a 5x5 unsigned weight filter and a 25x25 binary ifmap through write
// handshakes. Once a map has received its full count of in-range writes, it
// streams that map out as 32-bit packets: 25 filter packets (address order)
// and 25 ifmap row packets (row order). The two paths are independent.
//
// Ports:
//   clk        : single clock
//   rst_n      : asynchronous active-low reset
//   bus        : snn_input_mem_if.slave (write and packet channels)
//   filt_state : debug, filter FSM state (0 = LOAD, 1 = SEND)
//   ifm_state  : debug, ifmap FSM state  (0 = LOAD, 1 = SEND)
//
// Filter packet : {2'b00, row[2:0], col[2:0], 11'b0, weight zero-extended to 13b}
// Ifmap packet  : {2'b01, row[4:0], row_bits[24:0]}  (bit c = column c)
module snn_input_mem #(
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_DATA = 13,
  parameter int WIDTH_FW   = 7,
  parameter int DEPTH_F    = 5,
  parameter int DEPTH_I    = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  snn_input_mem_if.slave    bus,
  output logic              filt_state,
  output logic              ifm_state
);
  localparam int NF = DEPTH_F * DEPTH_F;
  localparam int NI = DEPTH_I * DEPTH_I;
  localparam logic [4:0] F_LAST   = 5'(NF - 1);
  localparam logic [4:0] F_COUNT  = 5'(NF);
  localparam logic [2:0] FC_LAST  = 3'(DEPTH_F - 1);
  localparam logic [9:0] I_LAST   = 10'(NI - 1);
  localparam logic [9:0] I_COUNT  = 10'(NI);
  localparam logic [4:0] IR_LAST  = 5'(DEPTH_I - 1);
  localparam logic [9:0] I_SIDE   = 10'(DEPTH_I);

  typedef enum logic {ST_LOAD = 1'b0, ST_SEND = 1'b1} state_t;

  // Ready must be low while reset is held and rise on the first edge after
  // release, so write-ready is qualified by this flag.
  logic alive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // ---------------------------------------------------------------- filter
  state_t              filt_st, filt_st_next;
  logic [WIDTH_FW-1:0] filt_mem [NF];
  logic [4:0]          wcnt;
  logic [4:0]          fidx;
  logic [2:0]          frow, fcol;
  logic                filt_wr_ready_c, filt_pkt_valid_c;
  logic                filt_wr_fire, filt_in_range, filt_pkt_fire;

  assign filt_wr_fire  = bus.filt_wr_valid && filt_wr_ready_c;
  assign filt_in_range = (bus.filt_wr_addr < F_COUNT);
  assign filt_pkt_fire = filt_pkt_valid_c && bus.filt_pkt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_st <= ST_LOAD;
    else        filt_st <= filt_st_next;
  end

  always_comb begin
    filt_st_next     = filt_st;
    filt_wr_ready_c  = 1'b0;
    filt_pkt_valid_c = 1'b0;
    case (filt_st)
      ST_LOAD: begin
        filt_wr_ready_c = alive;
        if (filt_wr_fire && filt_in_range && (wcnt == F_LAST))
          filt_st_next = ST_SEND;
      end
      ST_SEND: begin
        filt_pkt_valid_c = 1'b1;
        if (filt_pkt_fire && (fidx == F_LAST))
          filt_st_next = ST_LOAD;
      end
      default: filt_st_next = ST_LOAD;
    endcase
  end

  // Storage, write counter and send pointer. Row/col are tracked alongside
  // the flat index so the packet header needs no divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      fidx <= '0;
      frow <= '0;
      fcol <= '0;
      for (int i = 0; i < NF; i++) filt_mem[i] <= '0;
    end else begin
      if (filt_wr_fire && filt_in_range) begin
        filt_mem[bus.filt_wr_addr] <= bus.filt_wr_data;
        wcnt <= (wcnt == F_LAST) ? 5'd0 : wcnt + 5'd1;
      end
      if (filt_pkt_fire) begin
        if (fidx == F_LAST) begin
          fidx <= '0;
          frow <= '0;
          fcol <= '0;
        end else begin
          fidx <= fidx + 5'd1;
          if (fcol == FC_LAST) begin
            fcol <= '0;
            frow <= frow + 3'd1;
          end else begin
            fcol <= fcol + 3'd1;
          end
        end
      end
    end
  end

  assign bus.filt_wr_ready  = filt_wr_ready_c;
  assign bus.filt_pkt_valid = filt_pkt_valid_c;
  assign bus.filt_pkt_data  = filt_pkt_valid_c ?
      {2'b00, frow, fcol, {(WIDTH_PKT - 8 - WIDTH_DATA){1'b0}},
       {(WIDTH_DATA - WIDTH_FW){1'b0}}, filt_mem[fidx]} : '0;
  assign filt_state = (filt_st == ST_SEND);

  // ----------------------------------------------------------------- ifmap
  state_t             ifm_st, ifm_st_next;
  logic [DEPTH_I-1:0] ifm_rows [DEPTH_I];
  logic [9:0]         pcnt;
  logic [4:0]         irow;
  logic [4:0]         dec_row, dec_col;
  logic               ifm_wr_ready_c, ifm_pkt_valid_c;
  logic               ifm_wr_fire, ifm_in_range, ifm_pkt_fire;

  assign ifm_wr_fire  = bus.ifm_wr_valid && ifm_wr_ready_c;
  assign ifm_in_range = (bus.ifm_wr_addr < I_COUNT);
  assign ifm_pkt_fire = ifm_pkt_valid_c && bus.ifm_pkt_ready;

  // Constant divide; only meaningful when the address is in range, where
  // the quotient fits in 5 bits.
  assign dec_row = 5'(bus.ifm_wr_addr / I_SIDE);
  assign dec_col = 5'(bus.ifm_wr_addr - 10'(dec_row) * I_SIDE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifm_st <= ST_LOAD;
    else        ifm_st <= ifm_st_next;
  end

  always_comb begin
    ifm_st_next     = ifm_st;
    ifm_wr_ready_c  = 1'b0;
    ifm_pkt_valid_c = 1'b0;
    case (ifm_st)
      ST_LOAD: begin
        ifm_wr_ready_c = alive;
        if (ifm_wr_fire && ifm_in_range && (pcnt == I_LAST))
          ifm_st_next = ST_SEND;
      end
      ST_SEND: begin
        ifm_pkt_valid_c = 1'b1;
        if (ifm_pkt_fire && (irow == IR_LAST))
          ifm_st_next = ST_LOAD;
      end
      default: ifm_st_next = ST_LOAD;
    endcase
  end

  // Row registers are only cleared by reset; each timestep overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      irow <= '0;
      for (int i = 0; i < DEPTH_I; i++) ifm_rows[i] <= '0;
    end else begin
      if (ifm_wr_fire && ifm_in_range) begin
        ifm_rows[dec_row][dec_col] <= bus.ifm_wr_data;
        pcnt <= (pcnt == I_LAST) ? 10'd0 : pcnt + 10'd1;
      end
      if (ifm_pkt_fire)
        irow <= (irow == IR_LAST) ? 5'd0 : irow + 5'd1;
    end
  end

  assign bus.ifm_wr_ready  = ifm_wr_ready_c;
  assign bus.ifm_pkt_valid = ifm_pkt_valid_c;
  assign bus.ifm_pkt_data  = ifm_pkt_valid_c ? {2'b01, irow, ifm_rows[irow]} : '0;
  assign ifm_state = (ifm_st == ST_SEND);

endmodule

// File: tb/tb_snn_input_mem.sv
// tb_snn_input_mem -- self-checking bench for snn_input_mem.
// Expected packets are built from a reference copy of the stored maps and
// queued when the completing write is issued; monitors pop and compare them
// as packets transfer.
module tb_snn_input_mem;
  logic clk = 1'b0;
  logic rst_n;
  logic filt_state, ifm_state;

  always #5 clk = ~clk;

  snn_input_mem_if bus ();

  snn_input_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .filt_state (filt_state),
    .ifm_state  (ifm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] filt_q[$];
  logic [31:0] ifm_q[$];
  logic [31:0] filt_log[$];
  logic [31:0] ifm_log[$];

  logic [6:0]  fmem [25];
  logic [24:0] imem [25];
  int fcnt = 0;
  int icnt = 0;

  bit filt_stall = 0;
  bit ifm_rand   = 0;
  int ifm_hold   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] filt_pkt(input int k);
    logic [2:0] r, c;
    r = 3'(k / 5);
    c = 3'(k % 5);
    return {2'b00, r, c, 11'd0, 6'd0, fmem[k]};
  endfunction

  function automatic logic [31:0] ifm_pkt(input int r);
    logic [4:0] rr;
    rr = 5'(r);
    return {2'b01, rr, imem[r]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 25; i++) begin
      fmem[i] = '0;
      imem[i] = '0;
    end
    fcnt = 0;
    icnt = 0;
    filt_q.delete();
    ifm_q.delete();
  endtask

  // ------------------------------------------------------------ drivers
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic filt_write(input int addr, input int data);
    bit got = 0;
    bus.filt_wr_valid = 1'b1;
    bus.filt_wr_addr  = 5'(addr);
    bus.filt_wr_data  = 7'(data);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.filt_wr_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("filt_wr_timeout", 0, 1);
    else if (addr < 25) begin
      fmem[addr] = 7'(data);
      fcnt++;
      if (fcnt == 25) begin
        fcnt = 0;
        for (int k = 0; k < 25; k++) filt_q.push_back(filt_pkt(k));
      end
    end
    @(posedge clk);
    #1;
    bus.filt_wr_valid = 1'b0;
  endtask

  task automatic ifm_write(input int addr, input int data);
    bit got = 0;
    bus.ifm_wr_valid = 1'b1;
    bus.ifm_wr_addr  = 10'(addr);
    bus.ifm_wr_data  = 1'(data);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.ifm_wr_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ifm_wr_timeout", 0, 1);
    else if (addr < 625) begin
      imem[addr / 25][addr % 25] = 1'(data);
      icnt++;
      if (icnt == 625) begin
        icnt = 0;
        for (int r = 0; r < 25; r++) ifm_q.push_back(ifm_pkt(r));
      end
    end
    @(posedge clk);
    #1;
    bus.ifm_wr_valid = 1'b0;
  endtask

  task automatic wait_filt_drain();
    for (int i = 0; i < 3000 && filt_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("filt_drain", filt_q.size(), 0);
    check("filt_valid_after_pass", bus.filt_pkt_valid, 0);
    check("filt_ready_after_pass", bus.filt_wr_ready, 1);
  endtask

  task automatic wait_ifm_drain();
    for (int i = 0; i < 3000 && ifm_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("ifm_drain", ifm_q.size(), 0);
    check("ifm_valid_after_pass", bus.ifm_pkt_valid, 0);
    check("ifm_ready_after_pass", bus.ifm_wr_ready, 1);
  endtask

  // Packet-side ready drivers.
  initial begin
    bus.filt_pkt_ready = 1'b1;
    bus.ifm_pkt_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.filt_pkt_ready = !filt_stall;
      if (ifm_hold > 0) begin
        bus.ifm_pkt_ready = 1'b0;
        ifm_hold--;
      end else if (ifm_rand) begin
        bus.ifm_pkt_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.ifm_pkt_ready = 1'b1;
      end
    end
  end

  // ----------------------------------------------------------- monitors
  initial begin : filt_mon
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("filt_hold_valid", bus.filt_pkt_valid, 1);
          check("filt_hold_data", bus.filt_pkt_data, prev_data);
        end
        if (bus.filt_pkt_valid) check("filt_wr_ready_in_send", bus.filt_wr_ready, 0);
        if (bus.filt_pkt_valid && bus.filt_pkt_ready) begin
          if (filt_q.size() == 0) check("filt_unexpected_pkt", 1, 0);
          else check("filt_pkt", bus.filt_pkt_data, filt_q.pop_front());
          filt_log.push_back(bus.filt_pkt_data);
        end
        prev_stall = bus.filt_pkt_valid && !bus.filt_pkt_ready;
        prev_data  = bus.filt_pkt_data;
      end
    end
  end

  initial begin : ifm_mon
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("ifm_hold_valid", bus.ifm_pkt_valid, 1);
          check("ifm_hold_data", bus.ifm_pkt_data, prev_data);
        end
        if (bus.ifm_pkt_valid) check("ifm_wr_ready_in_send", bus.ifm_wr_ready, 0);
        if (bus.ifm_pkt_valid && bus.ifm_pkt_ready) begin
          if (ifm_q.size() == 0) check("ifm_unexpected_pkt", 1, 0);
          else check("ifm_pkt", bus.ifm_pkt_data, ifm_q.pop_front());
          ifm_log.push_back(bus.ifm_pkt_data);
        end
        prev_stall = bus.ifm_pkt_valid && !bus.ifm_pkt_ready;
        prev_data  = bus.ifm_pkt_data;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------- main
  initial begin
    rst_n = 1'b0;
    bus.filt_wr_valid = 1'b0;
    bus.filt_wr_addr  = '0;
    bus.filt_wr_data  = '0;
    bus.ifm_wr_valid  = 1'b0;
    bus.ifm_wr_addr   = '0;
    bus.ifm_wr_data   = 1'b0;
    clear_model();

    // Reset state
    #3;
    check("rst_filt_wr_ready", bus.filt_wr_ready, 0);
    check("rst_ifm_wr_ready", bus.ifm_wr_ready, 0);
    check("rst_filt_pkt_valid", bus.filt_pkt_valid, 0);
    check("rst_ifm_pkt_valid", bus.ifm_pkt_valid, 0);
    check("rst_filt_pkt_data", bus.filt_pkt_data, 0);
    check("rst_ifm_pkt_data", bus.ifm_pkt_data, 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_filt_wr_ready", bus.filt_wr_ready, 1);
    check("post_rst_ifm_wr_ready", bus.ifm_wr_ready, 1);
    check("post_rst_filt_state", filt_state, 0);
    check("post_rst_ifm_state", ifm_state, 0);

    // Filter 1..25 and checkerboard ifmap concurrently, ifmap backpressured
    filt_log.delete();
    ifm_log.delete();
    fork
      begin
        for (int k = 0; k < 25; k++) filt_write(k, k + 1);
        wait_filt_drain();
        check("filt_log_size", filt_log.size(), 25);
        if (filt_log.size() > 7) check("filt_pkt7_const", filt_log[7], 32'h0A00_0008);
      end
      begin
        for (int r = 0; r < 25; r++)
          for (int c = 0; c < 25; c++)
            ifm_write(r * 25 + c, (r + c) & 1);
        repeat (3) @(posedge clk);
        #1;
        ifm_rand = 1;
        ifm_hold = 10;
        wait_ifm_drain();
        ifm_rand = 0;
        check("ifm_log_size", ifm_log.size(), 25);
        if (ifm_log.size() > 1) begin
          check("ifm_row0_const", ifm_log[0], 32'h40AA_AAAA);
          check("ifm_row1_const", ifm_log[1], 32'h4355_5555);
        end
      end
    join

    // Boundaries: out-of-range writes, duplicate address, all-zero timestep
    fork
      begin
        filt_write(25, 99);
        filt_write(3, 9);
        filt_write(3, 17);
        for (int k = 0; k < 23; k++)
          if (k != 3) filt_write(k, $urandom_range(0, 127));
        check("filt_no_send_at_24", bus.filt_pkt_valid, 0);
        check("filt_state_load_at_24", filt_state, 0);
        filt_write(23, $urandom_range(0, 127));
        check("filt_send_valid", bus.filt_pkt_valid, 1);
        check("filt_send_wr_ready", bus.filt_wr_ready, 0);
        check("filt_send_state", filt_state, 1);
        wait_filt_drain();
      end
      begin
        ifm_write(700, 1);
        for (int a = 0; a < 624; a++) ifm_write(a, 0);
        check("ifm_no_send_at_624", bus.ifm_pkt_valid, 0);
        check("ifm_state_load_at_624", ifm_state, 0);
        ifm_write(624, 0);
        check("ifm_send_valid", bus.ifm_pkt_valid, 1);
        check("ifm_send_wr_ready", bus.ifm_wr_ready, 0);
        check("ifm_send_state", ifm_state, 1);
        wait_ifm_drain();
      end
    join

    // Reset mid-SEND (filter stalled) and mid-LOAD (ifmap partial)
    filt_stall = 1;
    repeat (2) @(posedge clk);
    #1;
    fork
      for (int k = 0; k < 25; k++) filt_write(k, $urandom_range(0, 127));
      for (int a = 0; a < 300; a++) ifm_write(a, $urandom_range(0, 1));
    join
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_filt_in_send", bus.filt_pkt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_filt_pkt_valid", bus.filt_pkt_valid, 0);
    check("mid_rst_ifm_pkt_valid", bus.ifm_pkt_valid, 0);
    check("mid_rst_filt_pkt_data", bus.filt_pkt_data, 0);
    check("mid_rst_filt_wr_ready", bus.filt_wr_ready, 0);
    check("mid_rst_ifm_wr_ready", bus.ifm_wr_ready, 0);
    clear_model();
    filt_stall = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_filt_wr_ready", bus.filt_wr_ready, 1);
    check("rerst_ifm_wr_ready", bus.ifm_wr_ready, 1);
    fork
      begin
        for (int k = 0; k < 24; k++) filt_write(k, $urandom_range(0, 127));
        check("rerst_filt_no_send_at_24", bus.filt_pkt_valid, 0);
        filt_write(24, $urandom_range(0, 127));
        check("rerst_filt_send_valid", bus.filt_pkt_valid, 1);
        wait_filt_drain();
      end
      begin
        for (int a = 300; a < 625; a++) ifm_write(a, 1);
        check("rerst_ifm_partial_discarded", bus.ifm_pkt_valid, 0);
      end
    join

    check("final_filt_q_empty", filt_q.size(), 0);
    check("final_ifm_q_empty", ifm_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
